// File: rtl/gpio_apb_master.sv
// rtl/gpio_apb_master.sv - APB master sequencing single GPIO bank register accesses
// Optional pready timeout enabled by defining APB_TIMEOUT_EN.
module gpio_apb_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_bank,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [1:0]            pselx,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("gpio_apb_master: TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nx;
    logic                    rsp_valid_nx, rsp_err_nx, pwrite_nx, penable_nx;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nx, pwdata_nx;
    logic [ADDR_WIDTH-1:0]   paddr_nx;
    logic [1:0]              pselx_nx;
    logic                    expired;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    always_ff @(posedge pclk) begin
        if (!presetn || state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!pready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Expiry is the last pready=0 ACCESS cycle; a pready on that edge still completes.
    assign expired = !pready && (wait_cnt == TIMEOUT_LAST);
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pselx     <= 2'd0;
            penable   <= 1'b0;
            pwdata    <= '0;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_err   <= rsp_err_nx;
            paddr     <= paddr_nx;
            pwrite    <= pwrite_nx;
            pselx     <= pselx_nx;
            penable   <= penable_nx;
            pwdata    <= pwdata_nx;
        end
    end

    // The bus registers double as the latched command for SETUP/ACCESS.
    always_comb begin
        state_nx     = state;
        rsp_valid_nx = rsp_valid;
        rsp_rdata_nx = rsp_rdata;
        rsp_err_nx   = rsp_err;
        paddr_nx     = paddr;
        pwrite_nx    = pwrite;
        pselx_nx     = pselx;
        penable_nx   = penable;
        pwdata_nx    = pwdata;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_bank == 2'd0) begin
                        state_nx     = RESP;
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = '0;
                    end else begin
                        state_nx   = SETUP;
                        pselx_nx   = cmd_bank;
                        paddr_nx   = cmd_addr;
                        pwrite_nx  = cmd_write;
                        pwdata_nx  = cmd_write ? cmd_wdata : '0;
                        penable_nx = 1'b0;
                    end
                end
            end
            SETUP: begin
                state_nx   = ACCESS;
                penable_nx = 1'b1;
            end
            ACCESS: begin
                if (pready || expired) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = !pready;
                    rsp_rdata_nx = (pready && !pwrite) ? prdata : '0;
                    pselx_nx     = 2'd0;
                    penable_nx   = 1'b0;
                    paddr_nx     = '0;
                    pwrite_nx    = 1'b0;
                    pwdata_nx    = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpio_apb_master.sv
// tb/tb_gpio_apb_master.sv - scoreboard bench for gpio_apb_master (timeout cases with APB_TIMEOUT_EN)
module tb_gpio_apb_master;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0] cmd_bank = 2'd0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic [2:0] paddr;
    logic       pwrite, penable;
    logic [1:0] pselx;
    logic [7:0] pwdata;
    logic [7:0] prdata = 8'hEE;
    logic       pready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    int         slave_waits = 0;
    bit         slave_stuck = 1'b0;
    logic [7:0] slave_rdata = 8'h00;
    int         acc_cycles = 0;

    gpio_apb_master #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .paddr(paddr), .pwrite(pwrite), .pselx(pselx), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // APB slave: pready after slave_waits ACCESS cycles; prdata is junk unless completing.
    always @(negedge pclk) begin
        if (pselx != 2'd0 && penable === 1'b1) begin
            pready = !slave_stuck && (acc_cycles >= slave_waits);
            prdata = pready ? slave_rdata : 8'hEE;
            acc_cycles++;
        end else begin
            pready     = 1'b0;
            prdata     = 8'hEE;
            acc_cycles = 0;
        end
    end

    // Scoreboard monitor: every cycle a response is presented it must match the queue head.
    always @(negedge pclk) begin
        if (presetn === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%0h err=%0b, required no response", rsp_rdata, rsp_err);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_q[0][7:0]);
                chk("rsp_err", rsp_err, exp_q[0][8]);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] b, input logic [2:0] a,
                         input logic [7:0] d, input bit push, input logic [8:0] exp);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("issue_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_bank  = b;
        cmd_addr  = a;
        cmd_wdata = d;
        if (push) exp_q.push_back(exp);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", (exp_q.size() == 0 && cmd_ready === 1'b1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        presetn = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus", {paddr, pwrite, pselx, penable, pwdata}, 0);
        presetn = 1'b1;
        tick();

        // Write, zero wait states
        slave_waits = 0;
        issue(1'b1, 2'd1, 3'd3, 8'hA5, 1'b1, {1'b0, 8'h00});
        chk("wr_setup_pselx", pselx, 1);
        chk("wr_setup_paddr", paddr, 3);
        chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_pwdata", pwdata, 8'hA5);
        chk("wr_setup_busy", busy, 1);
        chk("wr_setup_cmd_ready", cmd_ready, 0);
        tick();
        chk("wr_access_penable", penable, 1);
        chk("wr_access_pselx", pselx, 1);
        tick();
        chk("wr_resp_valid", rsp_valid, 1);
        chk("wr_resp_bus_idle", {paddr, pwrite, pselx, penable, pwdata}, 0);
        tick();
        chk("wr_idle_cmd_ready", cmd_ready, 1);
        chk("wr_idle_rsp_valid", rsp_valid, 0);

        // Read, two wait states
        slave_waits = 2;
        slave_rdata = 8'h3C;
        issue(1'b0, 2'd2, 3'd5, 8'hFF, 1'b1, {1'b0, 8'h3C});
        chk("rd_setup_pselx", pselx, 2);
        chk("rd_setup_pwdata", pwdata, 0);
        chk("rd_setup_pwrite", pwrite, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_access_bus", {penable, pselx, paddr}, {1'b1, 2'd2, 3'd5});
        end
        tick();
        chk("rd_resp_valid", rsp_valid, 1);
        wait_done();

        // Invalid bank
        slave_waits = 0;
        issue(1'b1, 2'd0, 3'd2, 8'h11, 1'b1, {1'b1, 8'h00});
        chk("inv_rsp_valid", rsp_valid, 1);
        chk("inv_pselx", pselx, 0);
        chk("inv_penable", penable, 0);
        wait_done();

        // Response backpressure with a pending command
        rsp_ready = 1'b0;
        slave_rdata = 8'h5A;
        issue(1'b0, 2'd3, 3'd1, 8'h00, 1'b1, {1'b0, 8'h5A});
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("bp_rsp_seen", rsp_valid, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_bank  = 2'd1;
        cmd_addr  = 3'd2;
        cmd_wdata = 8'h77;
        exp_q.push_back({1'b0, 8'h00});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {rsp_valid, cmd_ready, pselx}, {1'b1, 1'b0, 2'd0});
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_after_cmd_ready", cmd_ready, 1);
        chk("bp_after_rsp_valid", rsp_valid, 0);
        chk("bp_after_rdata_kept", rsp_rdata, 8'h5A);
        tick();
        cmd_valid = 1'b0;
        chk("bp_next_setup", {pselx, paddr, pwdata}, {2'd1, 3'd2, 8'h77});
        wait_done();

        // Reset during ACCESS
        slave_stuck = 1'b1;
        issue(1'b0, 2'd1, 3'd4, 8'h00, 1'b0, 9'd0);
        tick();
        tick();
        chk("rst_mid_in_access", penable, 1);
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        chk("rst_mid_bus", {pselx, penable}, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < 10; i++) tick();
        slave_stuck = 1'b0;

`ifdef APB_TIMEOUT_EN
        // Timeout abort after 4 ACCESS cycles
        slave_stuck = 1'b1;
        issue(1'b0, 2'd2, 3'd6, 8'h00, 1'b1, {1'b1, 8'h00});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_access_penable", penable, 1);
        end
        tick();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_bus_idle", {pselx, penable}, 0);
        wait_done();
        slave_stuck = 1'b0;

        // pready on the expiry cycle wins
        slave_waits = 3;
        slave_rdata = 8'hC3;
        issue(1'b0, 2'd2, 3'd6, 8'h00, 1'b1, {1'b0, 8'hC3});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_late_penable", penable, 1);
        end
        tick();
        chk("to_late_rsp_valid", rsp_valid, 1);
        wait_done();
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_apb_master.md
Name: gpio_apb_master

Overview:
- APB master that sequences register accesses to the GPIO bank slaves over the shared pselx-encoded APB bus.
- Accepts one command at a time from the SPI frame decoder on a valid/ready interface.
- Runs the APB SETUP/ACCESS phases and waits for pready.
- Returns read data or an error on a valid/ready response interface.

Parameters:
DATA_WIDTH, 8, APB data width (pwdata/prdata, cmd/rsp data)
ADDR_WIDTH, 3, APB register address width within a bank
TIMEOUT, 15, max ACCESS cycles waited for pready (used only with APB_TIMEOUT_EN); legal range 1..255

Ports:
pclk  in  1  clock, all logic on rising edge
presetn  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept command
cmd_write  in  1  1=write, 0=read
cmd_bank  in  2  target bank code driven onto pselx; 0 = no bank (invalid)
cmd_addr  in  ADDR_WIDTH  register address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  1 = invalid bank or timeout
busy  out  1  1 whenever state != IDLE
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pselx  out  2  APB bank select code, 0 = idle bus
penable  out  1  APB enable
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready

Behaviour:
- Reset (presetn=0 at a rising edge):
  - State goes to IDLE.
  - Next-cycle values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Bus: paddr=0, pwrite=0, pselx=0, penable=0, pwdata=0.
- Reset mid-transaction aborts it. No response is produced. The bus is idle on the next cycle.
- All outputs are registered. cmd_ready = (state==IDLE).
- State IDLE:
  - On cmd_valid&cmd_ready, latch write/bank/addr/wdata.
  - If cmd_bank==0: go to RESP with rsp_err=1, rsp_rdata=0. No bus cycle occurs.
  - Otherwise go to SETUP.
- State SETUP (exactly 1 cycle):
  - pselx=bank, paddr=addr, pwrite=write, pwdata = wdata if write else 0, penable=0.
  - Always goes to ACCESS.
- State ACCESS:
  - Same bus values as SETUP, with penable=1.
  - All bus outputs are held stable until pready=1 is sampled at a rising edge.
  - On pready=1: capture rsp_rdata = prdata for reads (0 for writes) and set rsp_err=0.
  - Bus returns to idle the same edge: pselx=0, penable=0, paddr=0, pwrite=0, pwdata=0. Go to RESP.
- State RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held until rsp_valid&rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0. rsp_rdata and rsp_err keep their last values.
- Timing:
  - A command accepted at edge N gives SETUP in cycle N+1 and ACCESS from N+2.
  - With zero wait states, rsp_valid is asserted from N+3.
  - Minimum throughput is 4 cycles per command with rsp_ready tied high.
- pready outside ACCESS is ignored. prdata is sampled only on the completing edge.
- No command is accepted while a response is pending: there is no overlap, and at most one transaction is outstanding.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT with pready still 0, the transfer aborts. Bus goes idle on that edge. Go to RESP with rsp_err=1, rsp_rdata=0.
  - If pready=1 on the same edge as expiry, pready wins and the transfer completes normally.
- Not defined: the counter is absent and ACCESS waits indefinitely for pready.

Test Plan:
- Write, zero-wait slave: cmd write bank=1 addr=3 wdata=A5 -> SETUP in N+1 (pselx=1, paddr=3, pwrite=1, penable=0); ACCESS in N+2; rsp_valid at N+3 with rsp_err=0, rsp_rdata=00; bus idle at N+3.
- Read, 2 wait states: slave returns prdata=3C -> penable held high for 3 ACCESS cycles with stable paddr/pselx; rsp_rdata=3C, rsp_err=0.
- Invalid bank: cmd bank=0 -> pselx stays 0 throughout; rsp_valid next cycle with rsp_err=1, rsp_rdata=00.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held; cmd_ready=0 and a pending cmd is not taken; after the handshake, cmd_ready=1 in the following cycle.
- Reset mid-ACCESS: presetn=0 for one edge while pready=0 -> next cycle pselx=0, penable=0, rsp_valid=0, cmd_ready=1; no response is ever issued.
- APB_TIMEOUT_EN, TIMEOUT=4, pready stuck 0 -> abort after 4 ACCESS cycles with rsp_err=1, rsp_rdata=00. Repeat with pready rising on the 4th cycle -> normal completion, rsp_err=0.
